exec_mem_regfile: RTL and testbench

Execution/storage core of the 16-bit single-cycle datapath. It holds the general-purpose register file, the ALU with its operand-B mux, the data memory and the write-back mux. Control signals come from the control and ALU-control units; instruction fields come from the decode logic. Reads and ALU/memory results are combinational; register-file and memory writes commit on the rising clock edge.

---
 rtl/exec_mem_regfile.sv | 138 +++++++++++++
 tb/tb_exec_mem_regfile.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/exec_mem_regfile.sv
// rtl/exec_mem_regfile.sv - register file, ALU, data memory and write-back mux of the 16-bit datapath
//
// Purpose:
//   Execution/storage core of a single-cycle 16-bit datapath. Every cycle is one
//   complete instruction: reads, ALU and memory results are combinational, and
//   register-file / data-memory writes commit on the rising clock edge.
//
// Ports:
//   clk              sole clock, all state updates on posedge
//   reset            synchronous active-low clear of all registers and memory words
//   reg_read_addr_1  port-A register index (ALU operand a)
//   reg_read_addr_2  port-B register index (operand b / store data)
//   reg_write_dest   register index written at the clock edge
//   reg_write_en     register-file write enable
//   imm              sign-extended immediate
//   alu_src          1: operand b = imm, 0: operand b = port-B data
//   alu_ctrl         ALU operation select
//   mem_write        data-memory write enable
//   mem_read         data-memory read enable (0 forces mem_read_data to 0)
//   mem_to_reg       1: write-back = memory data, 0: write-back = ALU result
//   reg_read_data_1  port-A data
//   reg_read_data_2  port-B data
//   alu_result       ALU result
//   zero             alu_result == 0
//   mem_read_data    data-memory read value
//   wb_data          write-back value presented to the register file

module exec_mem_regfile #(
  parameter int DMEM_WORDS = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  reg_read_addr_1,
  input  logic [2:0]  reg_read_addr_2,
  input  logic [2:0]  reg_write_dest,
  input  logic        reg_write_en,
  input  logic [15:0] imm,
  input  logic        alu_src,
  input  logic [2:0]  alu_ctrl,
  input  logic        mem_write,
  input  logic        mem_read,
  input  logic        mem_to_reg,
  output logic [15:0] reg_read_data_1,
  output logic [15:0] reg_read_data_2,
  output logic [15:0] alu_result,
  output logic        zero,
  output logic [15:0] mem_read_data,
  output logic [15:0] wb_data
);

  localparam int AW = $clog2(DMEM_WORDS);

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_NOT = 3'b010,
    ALU_SHL = 3'b011,
    ALU_SHR = 3'b100,
    ALU_AND = 3'b101,
    ALU_OR  = 3'b110,
    ALU_SLT = 3'b111
  } alu_op_e;

  logic [15:0] regs_q [8];
  logic [15:0] regs_d [8];
  logic [15:0] mem_q  [DMEM_WORDS];
  logic [15:0] mem_d  [DMEM_WORDS];

  logic [15:0] op_a;
  logic [15:0] op_b;
  logic        shamt_big;
  logic [AW-1:0] mem_idx;

  // Register read ports
  assign reg_read_data_1 = regs_q[reg_read_addr_1];
  assign reg_read_data_2 = regs_q[reg_read_addr_2];

  // ALU
  assign op_a      = reg_read_data_1;
  assign op_b      = alu_src ? imm : reg_read_data_2;
  // Shift amounts of 16 or more clear the result; only b[3:0] is meaningful otherwise.
  assign shamt_big = |op_b[15:4];

  always_comb begin
    alu_result = 16'h0000;
    case (alu_op_e'(alu_ctrl))
      ALU_ADD: alu_result = op_a + op_b;
      ALU_SUB: alu_result = op_a - op_b;
      ALU_NOT: alu_result = ~op_a;
      ALU_SHL: alu_result = shamt_big ? 16'h0000 : (op_a << op_b[3:0]);
      ALU_SHR: alu_result = shamt_big ? 16'h0000 : (op_a >> op_b[3:0]);
      ALU_AND: alu_result = op_a & op_b;
      ALU_OR:  alu_result = op_a | op_b;
      ALU_SLT: alu_result = {15'd0, (op_a < op_b)};
      default: alu_result = 16'h0000;
    endcase
  end

  assign zero = (alu_result == 16'h0000);

  // Byte address to word index: bit 0 dropped, bits above the memory size dropped,
  // so addresses wrap modulo the memory depth.
  assign mem_idx = alu_result[AW:1];

  assign mem_read_data = mem_read ? mem_q[mem_idx] : 16'h0000;
  assign wb_data       = mem_to_reg ? mem_read_data : alu_result;

  // Next-state for register file and memory; the two writes are independent.
  always_comb begin
    regs_d = regs_q;
    if (reg_write_en) begin
      regs_d[reg_write_dest] = wb_data;
    end
  end

  always_comb begin
    mem_d = mem_q;
    if (mem_write) begin
      mem_d[mem_idx] = reg_read_data_2;
    end
  end

  // Reset wins over any write presented in the same cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 8; i++) begin
        regs_q[i] <= 16'h0000;
      end
      for (int j = 0; j < DMEM_WORDS; j++) begin
        mem_q[j] <= 16'h0000;
      end
    end else begin
      regs_q <= regs_d;
      mem_q  <= mem_d;
    end
  end

endmodule

// File: tb/tb_exec_mem_regfile.sv
// tb/tb_exec_mem_regfile.sv - self-checking bench for exec_mem_regfile with a behavioural reference model

module tb_exec_mem_regfile;

  localparam int DW = 256;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  reg_read_addr_1;
  logic [2:0]  reg_read_addr_2;
  logic [2:0]  reg_write_dest;
  logic        reg_write_en;
  logic [15:0] imm;
  logic        alu_src;
  logic [2:0]  alu_ctrl;
  logic        mem_write;
  logic        mem_read;
  logic        mem_to_reg;
  logic [15:0] reg_read_data_1;
  logic [15:0] reg_read_data_2;
  logic [15:0] alu_result;
  logic        zero;
  logic [15:0] mem_read_data;
  logic [15:0] wb_data;

  always #5 clk = ~clk;

  exec_mem_regfile #(.DMEM_WORDS(DW)) dut (
    .clk             (clk),
    .reset           (reset),
    .reg_read_addr_1 (reg_read_addr_1),
    .reg_read_addr_2 (reg_read_addr_2),
    .reg_write_dest  (reg_write_dest),
    .reg_write_en    (reg_write_en),
    .imm             (imm),
    .alu_src         (alu_src),
    .alu_ctrl        (alu_ctrl),
    .mem_write       (mem_write),
    .mem_read        (mem_read),
    .mem_to_reg      (mem_to_reg),
    .reg_read_data_1 (reg_read_data_1),
    .reg_read_data_2 (reg_read_data_2),
    .alu_result      (alu_result),
    .zero            (zero),
    .mem_read_data   (mem_read_data),
    .wb_data         (wb_data)
  );

  int total = 0;
  int bad   = 0;
  int step  = 0;

  logic [15:0] m_regs [8];
  logic [15:0] m_mem  [DW];

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s step=%0d observed=%h expected=%h", tag, step, obs, exp);
    end
  endtask

  function automatic logic [15:0] m_alu(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    int unsigned ua = a;
    int unsigned ub = b;
    case (op)
      3'd0: return 16'((ua + ub) % 65536);
      3'd1: return 16'((ua + 65536 - ub) % 65536);
      3'd2: return 16'(65535 - ua);
      3'd3: return (ub >= 16) ? 16'h0000 : 16'((ua * (32'd1 << ub)) % 65536);
      3'd4: return (ub >= 16) ? 16'h0000 : 16'(ua / (32'd1 << ub));
      3'd5: return a & b;
      3'd6: return a | b;
      default: return (ua < ub) ? 16'h0001 : 16'h0000;
    endcase
  endfunction

  // One instruction: drive, check all outputs against the model before the edge,
  // then clock it and commit the model's writes.
  task automatic instr(input logic [2:0] ra1, input logic [2:0] ra2, input logic [2:0] rd,
                       input logic we, input logic [15:0] im, input logic src,
                       input logic [2:0] op, input logic mw, input logic mr, input logic m2r,
                       output logic [15:0] o_res, output logic o_z,
                       output logic [15:0] o_rd1, output logic [15:0] o_rd2,
                       output logic [15:0] o_mrd);
    logic [15:0] a, b_reg, b, res, mrd, wb;
    int idx;
    step++;
    reg_read_addr_1 = ra1; reg_read_addr_2 = ra2; reg_write_dest = rd;
    reg_write_en = we; imm = im; alu_src = src; alu_ctrl = op;
    mem_write = mw; mem_read = mr; mem_to_reg = m2r;
    #1;
    a     = m_regs[ra1];
    b_reg = m_regs[ra2];
    b     = src ? im : b_reg;
    res   = m_alu(op, a, b);
    idx   = (int'(res) / 2) % DW;
    mrd   = mr ? m_mem[idx] : 16'h0000;
    wb    = m2r ? mrd : res;
    chk("rd1", reg_read_data_1, a);
    chk("rd2", reg_read_data_2, b_reg);
    chk("alu", alu_result, res);
    chk("zero", {15'd0, zero}, (res == 16'h0000) ? 16'h0001 : 16'h0000);
    chk("mrd", mem_read_data, mrd);
    chk("wb", wb_data, wb);
    o_res = alu_result; o_z = zero; o_rd1 = reg_read_data_1;
    o_rd2 = reg_read_data_2; o_mrd = mem_read_data;
    @(posedge clk);
    if (mw) m_mem[idx] = b_reg;
    if (we) m_regs[rd] = wb;
    #1;
  endtask

  task automatic do_reset(input logic we, input logic mw);
    reset = 1'b0;
    reg_write_en = we; mem_write = mw;
    reg_write_dest = 3'($urandom_range(0, 7));
    imm = 16'($urandom); alu_src = 1'b1; alu_ctrl = 3'd0;
    @(posedge clk);
    for (int i = 0; i < 8; i++) m_regs[i] = 16'h0000;
    for (int i = 0; i < DW; i++) m_mem[i] = 16'h0000;
    #1;
    reset = 1'b1;
  endtask

  initial begin
    logic [15:0] r, d1, d2, md;
    logic z;

    reset = 1'b0;
    reg_read_addr_1 = 3'd0; reg_read_addr_2 = 3'd0; reg_write_dest = 3'd0;
    reg_write_en = 1'b0; imm = 16'h0000; alu_src = 1'b0; alu_ctrl = 3'd0;
    mem_write = 1'b0; mem_read = 1'b0; mem_to_reg = 1'b0;
    @(posedge clk); #1;
    do_reset(1'b1, 1'b1);

    // Reset state
    instr(0, 0, 0, 0, 16'h0000, 0, 3'd0, 0, 0, 0, r, z, d1, d2, md);
    chk("rst_alu", r, 16'h0000);
    chk("rst_zero", {15'd0, z}, 16'h0001);
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++)
        instr(3'(i), 3'(j), 0, 0, 16'h0000, 0, 3'd0, 0, 0, 0, r, z, d1, d2, md);
    for (int i = 0; i < DW; i++) begin
      instr(0, 0, 0, 0, 16'(2 * i), 1, 3'd0, 0, 1, 1, r, z, d1, d2, md);
      chk("rst_mem", md, 16'h0000);
    end

    // Immediate adds and register arithmetic
    instr(0, 0, 1, 1, 16'h0005, 1, 3'd0, 0, 0, 0, r, z, d1, d2, md);
    instr(0, 0, 2, 1, 16'hFFFD, 1, 3'd0, 0, 0, 0, r, z, d1, d2, md);
    instr(1, 2, 0, 0, 16'h0000, 0, 3'd0, 0, 0, 0, r, z, d1, d2, md);
    chk("r1", d1, 16'h0005);
    chk("r2", d2, 16'hFFFD);
    chk("add", r, 16'h0002);
    chk("add_zero", {15'd0, z}, 16'h0000);
    instr(1, 1, 0, 0, 16'h0000, 0, 3'd1, 0, 0, 0, r, z, d1, d2, md);
    chk("sub", r, 16'h0000);
    chk("sub_zero", {15'd0, z}, 16'h0001);

    // Remaining ALU ops with a = 16'h00F0
    instr(0, 0, 6, 1, 16'h00F0, 1, 3'd0, 0, 0, 0, r, z, d1, d2, md);
    instr(6, 0, 0, 0, 16'h0004, 1, 3'd3, 0, 0, 0, r, z, d1, d2, md); chk("shl", r, 16'h0F00);
    instr(6, 0, 0, 0, 16'h0004, 1, 3'd4, 0, 0, 0, r, z, d1, d2, md); chk("shr", r, 16'h000F);
    instr(6, 0, 0, 0, 16'h0FF0, 1, 3'd5, 0, 0, 0, r, z, d1, d2, md); chk("and", r, 16'h00F0);
    instr(6, 0, 0, 0, 16'h0F0F, 1, 3'd6, 0, 0, 0, r, z, d1, d2, md); chk("or", r, 16'h0FFF);
    instr(6, 0, 0, 0, 16'h0004, 1, 3'd2, 0, 0, 0, r, z, d1, d2, md); chk("not", r, 16'hFF0F);
    instr(6, 0, 0, 0, 16'h0004, 1, 3'd7, 0, 0, 0, r, z, d1, d2, md); chk("slt0", r, 16'h0000);
    instr(0, 0, 7, 1, 16'h0003, 1, 3'd0, 0, 0, 0, r, z, d1, d2, md);
    instr(7, 0, 0, 0, 16'h8000, 1, 3'd7, 0, 0, 0, r, z, d1, d2, md); chk("slt1", r, 16'h0001);

    // Shifts by 16 or more
    instr(0, 0, 1, 1, 16'h0001, 1, 3'd0, 0, 0, 0, r, z, d1, d2, md);
    instr(1, 0, 0, 0, 16'h0010, 1, 3'd3, 0, 0, 0, r, z, d1, d2, md); chk("shl16", r, 16'h0000);
    instr(1, 0, 0, 0, 16'h0010, 1, 3'd4, 0, 0, 0, r, z, d1, d2, md); chk("shr16", r, 16'h0000);
    instr(1, 0, 0, 0, 16'h0F00, 1, 3'd3, 0, 0, 0, r, z, d1, d2, md); chk("shl_big", r, 16'h0000);
    instr(1, 0, 0, 0, 16'h000F, 1, 3'd3, 0, 0, 0, r, z, d1, d2, md); chk("shl15", r, 16'h8000);

    // Store/load round trip, aliasing, bit 0 ignored, mem_read gating
    instr(0, 0, 3, 1, 16'hBEEF, 1, 3'd0, 0, 0, 0, r, z, d1, d2, md);
    instr(0, 3, 0, 0, 16'd10, 1, 3'd0, 1, 0, 0, r, z, d1, d2, md);
    instr(0, 0, 4, 1, 16'd10, 1, 3'd0, 0, 1, 1, r, z, d1, d2, md); chk("load", md, 16'hBEEF);
    instr(4, 0, 0, 0, 16'h0000, 0, 3'd0, 0, 0, 0, r, z, d1, d2, md); chk("r4", d1, 16'hBEEF);
    instr(0, 0, 0, 0, 16'(10 + 2 * DW), 1, 3'd0, 0, 1, 1, r, z, d1, d2, md); chk("alias", md, 16'hBEEF);
    instr(0, 0, 0, 0, 16'd11, 1, 3'd0, 0, 1, 1, r, z, d1, d2, md); chk("odd_addr", md, 16'hBEEF);
    instr(0, 0, 4, 1, 16'd10, 1, 3'd0, 0, 0, 1, r, z, d1, d2, md); chk("noread", md, 16'h0000);
    instr(4, 0, 0, 0, 16'h0000, 0, 3'd0, 0, 0, 0, r, z, d1, d2, md); chk("r4_zero", d1, 16'h0000);
    instr(0, 3, 0, 0, 16'd20, 1, 3'd0, 1, 1, 0, r, z, d1, d2, md); chk("mem_rdw_old", md, 16'h0000);
    instr(0, 0, 0, 0, 16'd20, 1, 3'd0, 0, 1, 0, r, z, d1, d2, md); chk("mem_rdw_new", md, 16'hBEEF);

    // Same-cycle read and write of r5
    instr(0, 0, 5, 1, 16'h1111, 1, 3'd0, 0, 0, 0, r, z, d1, d2, md);
    instr(0, 5, 5, 1, 16'h2222, 1, 3'd0, 0, 0, 0, r, z, d1, d2, md); chk("r5_old", d2, 16'h1111);
    instr(5, 0, 5, 0, 16'h3333, 1, 3'd0, 0, 0, 0, r, z, d1, d2, md); chk("r5_new", d1, 16'h2222);
    instr(5, 0, 0, 0, 16'h0000, 0, 3'd0, 0, 0, 0, r, z, d1, d2, md); chk("r5_keep", d1, 16'h2222);

    // Reset discards writes presented in the same cycle
    reg_read_addr_2 = 3'd3;
    do_reset(1'b1, 1'b1);
    instr(5, 3, 0, 0, 16'h0000, 0, 3'd0, 0, 0, 0, r, z, d1, d2, md);
    chk("rst_r5", d1, 16'h0000);
    chk("rst_r3", d2, 16'h0000);
    instr(0, 0, 0, 0, 16'd10, 1, 3'd0, 0, 1, 1, r, z, d1, d2, md); chk("rst_m10", md, 16'h0000);
    instr(0, 0, 0, 0, 16'd20, 1, 3'd0, 0, 1, 1, r, z, d1, d2, md); chk("rst_m20", md, 16'h0000);

    // Randomized instructions against the model
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 49) == 0) begin
        do_reset(1'($urandom), 1'($urandom));
      end else begin
        instr(3'($urandom), 3'($urandom), 3'($urandom), 1'($urandom),
              ($urandom_range(0, 1) == 0) ? 16'($urandom) : 16'($urandom_range(0, 40)),
              1'($urandom), 3'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
              r, z, d1, d2, md);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
